// File: rtl/phv_ingress_cfg_ctrl_pkg.sv
// Shared constants for the parser ingress front end: beat flags, header layout,
// response codes and controller state encoding.
package phv_ingress_cfg_ctrl_pkg;

  localparam int unsigned PKT_W    = 134;
  localparam int unsigned FLAG_LSB = 132;

  localparam logic [1:0] FLAG_HEAD = 2'b01;
  localparam logic [1:0] FLAG_MID  = 2'b11;
  localparam logic [1:0] FLAG_TAIL = 2'b10;

  localparam int unsigned HDR_KIND_BIT  = 0;
  localparam int unsigned HDR_READ_BIT  = 8;
  localparam int unsigned HDR_ADDR_LSB  = 16;
  localparam int unsigned HDR_STAGE_LSB = 24;
  localparam int unsigned HDR_STAGE_W   = 8;

  localparam logic [1:0] RSP_OK        = 2'd0;
  localparam logic [1:0] RSP_TIMEOUT   = 2'd1;
  localparam logic [1:0] RSP_BAD_STAGE = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_META,
    ST_PHV_HOLD,
    ST_CFG_HI,
    ST_CFG_LO,
    ST_RD_WAIT,
    ST_RSP,
    ST_DROP
  } state_e;

endpackage

// File: rtl/phv_ingress_cfg_ctrl_deser.sv
// Metadata deserialiser: beat counter, MSB-first PHV insert register and
// per-beat framing classification for the controller FSM.
module phv_beat_deser
  import phv_ingress_cfg_ctrl_pkg::*;
#(
  parameter int unsigned BEAT_W = 128,
  parameter int unsigned PHV_W  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              beat_valid,
  input  logic [1:0]        beat_flag,
  input  logic [BEAT_W-1:0] beat_payload,
  output logic [PHV_W-1:0]  metadata,
  output logic              done_c,
  output logic              early_tail_c,
  output logic              bad_last_c
);

  localparam int unsigned META_BEATS = PHV_W / BEAT_W;
  localparam int unsigned CNT_W      = (META_BEATS > 1) ? $clog2(META_BEATS) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PHV_W-1:0] meta_q, meta_d;
  logic             is_last;
  logic             is_tail;

  assign is_last      = (cnt_q == CNT_W'(META_BEATS - 1));
  assign is_tail      = (beat_flag == FLAG_TAIL);
  assign done_c       = beat_valid && is_last && is_tail;
  assign early_tail_c = beat_valid && !is_last && is_tail;
  assign bad_last_c   = beat_valid && is_last && !is_tail;
  assign metadata     = meta_q;

  // Counter restarts on every header and after any tail or last-index beat.
  always_comb begin
    cnt_d  = cnt_q;
    meta_d = meta_q;
    if (start) begin
      cnt_d = '0;
    end else if (beat_valid) begin
      cnt_d = (is_last || is_tail) ? '0 : cnt_q + CNT_W'(1);
      for (int unsigned b = 0; b < META_BEATS; b++) begin
        if (cnt_q == CNT_W'(b)) begin
          meta_d[PHV_W-1-b*BEAT_W -: BEAT_W] = beat_payload;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      meta_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      meta_q <= meta_d;
    end
  end

endmodule

// File: rtl/phv_ingress_cfg_ctrl.sv
// Parser ingress front end: builds PHVs from metadata packets, dispatches rule
// writes/reads to the parser stages and returns read-back responses.
module phv_ingress_cfg_ctrl
  import phv_ingress_cfg_ctrl_pkg::*;
#(
  parameter int unsigned BEAT_W     = 128,
  parameter int unsigned PHV_W      = 1024,
  parameter int unsigned TYPE_W     = 160,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned RULE_W     = 177,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned RD_TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pktin_data_wr,
  input  logic [PKT_W-1:0]             pktin_data,
  output logic                         pktin_ready,
  output logic                         phv_out_valid,
  output logic [PHV_W+TYPE_W-1:0]      phv_out,
  input  logic                         phv_out_ready,
  output logic [NUM_STAGES-1:0]        wren_rule,
  output logic [NUM_STAGES-1:0]        rden_rule,
  output logic [ADDR_W-1:0]            addr_rule,
  output logic [RULE_W-1:0]            data_rule,
  input  logic [NUM_STAGES-1:0]        rdata_rule_valid,
  input  logic [NUM_STAGES*RULE_W-1:0] rdata_rule,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [1:0]                   rsp_status,
  output logic [RULE_W-1:0]            rsp_data,
  output logic [15:0]                  err_drop_cnt
);

  localparam int unsigned TMR_W = $clog2(RD_TIMEOUT + 1);

  state_e                  state_q, state_d;
  logic [TYPE_W-1:0]       type_info_q, type_info_d;
  logic [TYPE_W-1:0]       phv_type_q, phv_type_d;
  logic                    phv_valid_q, phv_valid_d;
  logic                    hdr_read_q, hdr_read_d;
  logic [ADDR_W-1:0]       hdr_addr_q, hdr_addr_d;
  logic [HDR_STAGE_W-1:0]  hdr_stage_q, hdr_stage_d;
  logic [NUM_STAGES-1:0]   sel_q, sel_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic [NUM_STAGES-1:0]   wren_q, wren_d;
  logic [NUM_STAGES-1:0]   rden_q, rden_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [RULE_W-1:0]       data_q, data_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [1:0]              rsp_status_q, rsp_status_d;
  logic [RULE_W-1:0]       rsp_data_q, rsp_data_d;
  logic [15:0]             err_q, err_d;

  logic [1:0]              flag_c;
  logic [BEAT_W-1:0]       payload_c;
  logic                    beat_fire_c;
  logic                    meta_start_c;
  logic                    err_inc_c;
  logic [RULE_W-1:0]       full_rule_c;
  logic [RULE_W-1:0]       rd_mux_c;
  logic [NUM_STAGES-1:0]   stage_oh_c;
  logic                    stage_zero_c;
  logic                    stage_ok_c;
  logic [PHV_W-1:0]        metadata;
  logic                    meta_done_c;
  logic                    meta_early_c;
  logic                    meta_bad_c;
  logic                    unused_pkt_bits;

  assign flag_c          = pktin_data[FLAG_LSB +: 2];
  assign payload_c       = pktin_data[BEAT_W-1:0];
  assign unused_pkt_bits = ^pktin_data[FLAG_LSB-1:BEAT_W];
  assign beat_fire_c     = pktin_data_wr && pktin_ready;
  assign full_rule_c     = {data_q[RULE_W-1:BEAT_W], payload_c};
  assign stage_zero_c    = (hdr_stage_q == '0);
  assign stage_ok_c      = !stage_zero_c && (hdr_stage_q <= HDR_STAGE_W'(NUM_STAGES));

  assign pktin_ready = (state_q == ST_IDLE)   || (state_q == ST_META) ||
                       (state_q == ST_CFG_HI) || (state_q == ST_CFG_LO) ||
                       (state_q == ST_DROP);

  assign phv_out_valid = phv_valid_q;
  assign phv_out       = {phv_type_q, metadata};
  assign wren_rule     = wren_q;
  assign rden_rule     = rden_q;
  assign addr_rule     = addr_q;
  assign data_rule     = data_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_status    = rsp_status_q;
  assign rsp_data      = rsp_data_q;
  assign err_drop_cnt  = err_q;

  phv_beat_deser #(
    .BEAT_W (BEAT_W),
    .PHV_W  (PHV_W)
  ) u_deser (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (meta_start_c),
    .beat_valid   (beat_fire_c && (state_q == ST_META)),
    .beat_flag    (flag_c),
    .beat_payload (payload_c),
    .metadata     (metadata),
    .done_c       (meta_done_c),
    .early_tail_c (meta_early_c),
    .bad_last_c   (meta_bad_c)
  );

  // Stage decode and read-data select for the addressed stage.
  always_comb begin
    stage_oh_c = '0;
    rd_mux_c   = '0;
    for (int unsigned s = 0; s < NUM_STAGES; s++) begin
      stage_oh_c[s] = (hdr_stage_q == HDR_STAGE_W'(s + 1));
      if (sel_q[s]) begin
        rd_mux_c = rd_mux_c | rdata_rule[s*RULE_W +: RULE_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    type_info_d  = type_info_q;
    phv_type_d   = phv_type_q;
    phv_valid_d  = phv_valid_q;
    hdr_read_d   = hdr_read_q;
    hdr_addr_d   = hdr_addr_q;
    hdr_stage_d  = hdr_stage_q;
    sel_d        = sel_q;
    tmr_d        = tmr_q;
    wren_d       = '0;
    rden_d       = '0;
    addr_d       = addr_q;
    data_d       = data_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;
    meta_start_c = 1'b0;
    err_inc_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (beat_fire_c) begin
          if (flag_c == FLAG_HEAD) begin
            hdr_read_d   = payload_c[HDR_READ_BIT];
            hdr_addr_d   = payload_c[HDR_ADDR_LSB +: ADDR_W];
            hdr_stage_d  = payload_c[HDR_STAGE_LSB +: HDR_STAGE_W];
            meta_start_c = 1'b1;
            state_d      = payload_c[HDR_KIND_BIT] ? ST_CFG_HI : ST_META;
          end else begin
            err_inc_c = 1'b1;
            state_d   = ST_DROP;
          end
        end
      end
      ST_META: begin
        if (meta_done_c) begin
          phv_type_d  = type_info_q;
          phv_valid_d = 1'b1;
          state_d     = ST_PHV_HOLD;
        end else if (meta_early_c) begin
          err_inc_c = 1'b1;
          state_d   = ST_IDLE;
        end else if (meta_bad_c) begin
          err_inc_c = 1'b1;
          state_d   = ST_DROP;
        end
      end
      ST_PHV_HOLD: begin
        if (phv_out_ready) begin
          phv_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_CFG_HI: begin
        if (beat_fire_c) begin
          if (flag_c == FLAG_TAIL) begin
            err_inc_c = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            data_d[RULE_W-1:BEAT_W] = payload_c[RULE_W-BEAT_W-1:0];
            state_d                 = ST_CFG_LO;
          end
        end
      end
      ST_CFG_LO: begin
        if (beat_fire_c) begin
          data_d[BEAT_W-1:0] = payload_c;
          if (flag_c != FLAG_TAIL) begin
            err_inc_c = 1'b1;
            state_d   = ST_DROP;
          end else if (!hdr_read_q) begin
            state_d = ST_IDLE;
            if (stage_zero_c) begin
              type_info_d = full_rule_c[TYPE_W-1:0];
            end else if (stage_ok_c) begin
              wren_d = stage_oh_c;
              addr_d = hdr_addr_q;
            end else begin
              err_inc_c = 1'b1;
            end
          end else if (stage_ok_c) begin
            rden_d  = stage_oh_c;
            addr_d  = hdr_addr_q;
            sel_d   = stage_oh_c;
            tmr_d   = '0;
            state_d = ST_RD_WAIT;
          end else begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = stage_zero_c ? RSP_OK : RSP_BAD_STAGE;
            rsp_data_d   = stage_zero_c ? RULE_W'(type_info_q) : '0;
            state_d      = ST_RSP;
          end
        end
      end
      ST_RD_WAIT: begin
        if (|(sel_q & rdata_rule_valid)) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = RSP_OK;
          rsp_data_d   = rd_mux_c;
          state_d      = ST_RSP;
        end else if (tmr_q == TMR_W'(RD_TIMEOUT - 1)) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = RSP_TIMEOUT;
          rsp_data_d   = '0;
          state_d      = ST_RSP;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (beat_fire_c && (flag_c == FLAG_TAIL)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    err_d = (err_inc_c && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      type_info_q  <= '0;
      phv_type_q   <= '0;
      phv_valid_q  <= 1'b0;
      hdr_read_q   <= 1'b0;
      hdr_addr_q   <= '0;
      hdr_stage_q  <= '0;
      sel_q        <= '0;
      tmr_q        <= '0;
      wren_q       <= '0;
      rden_q       <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= RSP_OK;
      rsp_data_q   <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      type_info_q  <= type_info_d;
      phv_type_q   <= phv_type_d;
      phv_valid_q  <= phv_valid_d;
      hdr_read_q   <= hdr_read_d;
      hdr_addr_q   <= hdr_addr_d;
      hdr_stage_q  <= hdr_stage_d;
      sel_q        <= sel_d;
      tmr_q        <= tmr_d;
      wren_q       <= wren_d;
      rden_q       <= rden_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_phv_ingress_cfg_ctrl.sv
// Directed self-checking bench for phv_ingress_cfg_ctrl: PHV build, backpressure,
// rule write/read dispatch, read timeout, framing errors and mid-packet reset.
module tb_phv_ingress_cfg_ctrl;

  localparam int unsigned BEAT_W = 128;
  localparam int unsigned PHV_W  = 1024;
  localparam int unsigned TYPE_W = 160;
  localparam int unsigned NS     = 3;
  localparam int unsigned RULE_W = 177;
  localparam int unsigned ADDR_W = 3;

  localparam logic [1:0] F_HEAD = 2'b01;
  localparam logic [1:0] F_MID  = 2'b11;
  localparam logic [1:0] F_TAIL = 2'b10;

  logic                     clk;
  logic                     rst_n;
  logic                     pktin_data_wr;
  logic [133:0]             pktin_data;
  logic                     pktin_ready;
  logic                     phv_out_valid;
  logic [PHV_W+TYPE_W-1:0]  phv_out;
  logic                     phv_out_ready;
  logic [NS-1:0]            wren_rule;
  logic [NS-1:0]            rden_rule;
  logic [ADDR_W-1:0]        addr_rule;
  logic [RULE_W-1:0]        data_rule;
  logic [NS-1:0]            rdata_rule_valid;
  logic [NS*RULE_W-1:0]     rdata_rule;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [1:0]               rsp_status;
  logic [RULE_W-1:0]        rsp_data;
  logic [15:0]              err_drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  phv_ingress_cfg_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pktin_data_wr    (pktin_data_wr),
    .pktin_data       (pktin_data),
    .pktin_ready      (pktin_ready),
    .phv_out_valid    (phv_out_valid),
    .phv_out          (phv_out),
    .phv_out_ready    (phv_out_ready),
    .wren_rule        (wren_rule),
    .rden_rule        (rden_rule),
    .addr_rule        (addr_rule),
    .data_rule        (data_rule),
    .rdata_rule_valid (rdata_rule_valid),
    .rdata_rule       (rdata_rule),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_status       (rsp_status),
    .rsp_data         (rsp_data),
    .err_drop_cnt     (err_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] hdr(input logic kind, input logic rd,
                                       input logic [2:0] addr, input logic [7:0] stage);
    logic [127:0] h;
    h        = '0;
    h[0]     = kind;
    h[8]     = rd;
    h[18:16] = addr;
    h[31:24] = stage;
    return h;
  endfunction

  task automatic send_beat(input logic [1:0] flag, input logic [127:0] payload);
    int n;
    n             = 0;
    pktin_data_wr = 1'b1;
    pktin_data    = {flag, 4'b0, payload};
    while (!pktin_ready && n < 100) begin
      step();
      n++;
    end
    check_eq("beat_ready", 256'(pktin_ready), 256'(1));
    step();
    pktin_data_wr = 1'b0;
  endtask

  task automatic send_meta(input int base, input int nbeats, input int tail_at);
    send_beat(F_HEAD, hdr(1'b0, 1'b0, 3'd0, 8'd0));
    for (int i = 0; i < nbeats; i++) begin
      send_beat((i == tail_at) ? F_TAIL : F_MID, 128'(base + i));
    end
  endtask

  task automatic send_cfg(input logic rd, input logic [7:0] stage, input logic [2:0] addr,
                          input logic [RULE_W-1:0] d);
    send_beat(F_HEAD, hdr(1'b1, rd, addr, stage));
    send_beat(F_MID, 128'(d[RULE_W-1:BEAT_W]));
    send_beat(F_TAIL, d[BEAT_W-1:0]);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 200) begin
      step();
      n++;
    end
    check_eq("rsp_valid_seen", 256'(rsp_valid), 256'(1));
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_eq("rsp_released", 256'(rsp_valid), 256'(0));
  endtask

  task automatic check_phv(input string tag, input int first, input int last,
                           input logic [TYPE_W-1:0] ti);
    check_eq({tag, "_valid"}, 256'(phv_out_valid), 256'(1));
    check_eq({tag, "_top"}, 256'(phv_out[PHV_W-1 -: BEAT_W]), 256'(first));
    check_eq({tag, "_bot"}, 256'(phv_out[BEAT_W-1:0]), 256'(last));
    check_eq({tag, "_type"}, 256'(phv_out[PHV_W+TYPE_W-1:PHV_W]), 256'(ti));
  endtask

  initial begin
    logic [PHV_W+TYPE_W-1:0] snap;
    logic [RULE_W-1:0]       d;
    int                      bad;
    int                      n;

    clk              = 1'b0;
    rst_n            = 1'b0;
    pktin_data_wr    = 1'b0;
    pktin_data       = '0;
    phv_out_ready    = 1'b0;
    rdata_rule_valid = '0;
    rdata_rule       = '0;
    rsp_ready        = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    check_eq("rst_phv_valid", 256'(phv_out_valid), 256'(0));
    check_eq("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    check_eq("rst_wren", 256'(wren_rule), 256'(0));
    check_eq("rst_err", 256'(err_drop_cnt), 256'(0));
    check_eq("rst_ready", 256'(pktin_ready), 256'(1));

    // Type info 0xA5 then a PHV taken immediately.
    send_cfg(1'b0, 8'd0, 3'd0, RULE_W'(128'hA5));
    phv_out_ready = 1'b1;
    send_meta(0, 8, 7);
    check_phv("phv1", 0, 7, TYPE_W'(8'hA5));
    step();
    check_eq("phv1_one_cycle", 256'(phv_out_valid), 256'(0));

    // Backpressure: PHV held, next head not accepted.
    phv_out_ready = 1'b0;
    send_meta(16, 8, 7);
    check_phv("phv2", 16, 23, TYPE_W'(8'hA5));
    snap          = phv_out;
    bad           = 0;
    pktin_data_wr = 1'b1;
    pktin_data    = {F_HEAD, 4'b0, hdr(1'b0, 1'b0, 3'd0, 8'd0)};
    for (int i = 0; i < 20; i++) begin
      step();
      if (phv_out !== snap || phv_out_valid !== 1'b1 || pktin_ready !== 1'b0) bad++;
    end
    check_eq("hold_stable", 256'(bad), 256'(0));
    phv_out_ready = 1'b1;
    send_meta(100, 8, 7);
    check_phv("phv3", 100, 107, TYPE_W'(8'hA5));
    step();

    // Rule write to stage 2.
    d = {49'h1_2345_6789_ABCD, 128'h1};
    send_cfg(1'b0, 8'd2, 3'd5, d);
    check_eq("wr_wren", 256'(wren_rule), 256'(3'b010));
    check_eq("wr_addr", 256'(addr_rule), 256'(5));
    check_eq("wr_data", 256'(data_rule), 256'(d));
    step();
    check_eq("wr_pulse_end", 256'(wren_rule), 256'(0));
    check_eq("wr_addr_held", 256'(addr_rule), 256'(5));

    // Read stage 3, answered on the 4th cycle; a stage-1 valid at the same time is ignored.
    send_cfg(1'b1, 8'd3, 3'd2, '0);
    check_eq("rd3_rden", 256'(rden_rule), 256'(3'b100));
    check_eq("rd3_addr", 256'(addr_rule), 256'(2));
    repeat (3) step();
    rdata_rule       = '0;
    rdata_rule[2*RULE_W +: RULE_W] = RULE_W'(8'h1F);
    rdata_rule[0 +: RULE_W]        = RULE_W'(16'hDEAD);
    rdata_rule_valid = 3'b101;
    step();
    rdata_rule_valid = '0;
    wait_rsp(n);
    check_eq("rd3_status", 256'(rsp_status), 256'(0));
    check_eq("rd3_data", 256'(rsp_data), 256'(8'h1F));
    repeat (2) step();
    check_eq("rd3_held", 256'(rsp_valid), 256'(1));
    release_rsp();

    // Read stage 1, never answered.
    send_cfg(1'b1, 8'd1, 3'd1, '0);
    check_eq("rd1_rden", 256'(rden_rule), 256'(3'b001));
    wait_rsp(n);
    check_eq("rd1_latency", 256'(n), 256'(64));
    check_eq("rd1_status", 256'(rsp_status), 256'(1));
    check_eq("rd1_data", 256'(rsp_data), 256'(0));
    release_rsp();

    // Read stage 7 (absent) and stage 0 (type info).
    send_cfg(1'b1, 8'd7, 3'd0, '0);
    check_eq("rd7_rden", 256'(rden_rule), 256'(0));
    wait_rsp(n);
    check_eq("rd7_status", 256'(rsp_status), 256'(2));
    check_eq("rd7_data", 256'(rsp_data), 256'(0));
    release_rsp();
    send_cfg(1'b1, 8'd0, 3'd0, '0);
    wait_rsp(n);
    check_eq("rd0_status", 256'(rsp_status), 256'(0));
    check_eq("rd0_data", 256'(rsp_data), 256'(8'hA5));
    release_rsp();
    check_eq("err_before_frame", 256'(err_drop_cnt), 256'(0));

    // Early tail on beat 4 is dropped, next packet delivered.
    send_meta(50, 5, 4);
    repeat (2) step();
    check_eq("early_no_valid", 256'(phv_out_valid), 256'(0));
    check_eq("early_err", 256'(err_drop_cnt), 256'(1));
    send_meta(200, 8, 7);
    check_phv("phv4", 200, 207, TYPE_W'(8'hA5));
    step();

    // Reset in the middle of a metadata packet.
    send_meta(70, 4, -1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 256'(phv_out_valid), 256'(0));
    check_eq("mid_rst_phv", 256'(|phv_out), 256'(0));
    check_eq("mid_rst_err", 256'(err_drop_cnt), 256'(0));
    check_eq("mid_rst_strobes", 256'({wren_rule, rden_rule, rsp_valid}), 256'(0));
    check_eq("mid_rst_data", 256'(data_rule), 256'(0));
    repeat (2) step();
    rst_n = 1'b1;
    step();
    send_meta(300, 8, 7);
    check_phv("phv5", 300, 307, TYPE_W'(0));
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/phv_ingress_cfg_ctrl.md
Name: phv_ingress_cfg_ctrl

Overview:
- Front end of the parser pipeline, sitting between the 134-bit port/CPU beat stream and the chained parser_deparser stages.
- Deserialises metadata packets into a PHV and prepends the programmed initial type info.
- Dispatches rule writes/reads to NUM_STAGES stages and returns read-back responses.
- Adds beat framing checks, PHV backpressure and a readback timeout.

Parameters:
- BEAT_W, 128, payload bits per beat (pktin_data[BEAT_W-1:0]).
- PHV_W, 1024, metadata bits per PHV; multiple of BEAT_W; META_BEATS = PHV_W/BEAT_W.
- TYPE_W, 160, initial type-info width; TYPE_W <= RULE_W.
- NUM_STAGES, 3, number of parser stages (1..8).
- RULE_W, 177, rule width; BEAT_W < RULE_W <= 2*BEAT_W.
- ADDR_W, 3, rule address width.
- RD_TIMEOUT, 64, cycles to wait for rdata_rule_valid.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- pktin_data_wr  in  1  beat strobe
- pktin_data  in  134  [133:132] flag: 01 head, 11 middle, 10 tail; [BEAT_W-1:0] payload
- pktin_ready  out  1  beat acceptance
- phv_out_valid  out  1  PHV valid
- phv_out  out  PHV_W+TYPE_W  {type_info, metadata}
- phv_out_ready  in  1  downstream accept
- wren_rule  out  NUM_STAGES  one-hot write strobe
- rden_rule  out  NUM_STAGES  one-hot read strobe
- addr_rule  out  ADDR_W  rule address
- data_rule  out  RULE_W  rule data
- rdata_rule_valid  in  NUM_STAGES  per-stage read-valid
- rdata_rule  in  NUM_STAGES*RULE_W  per-stage read data, stage s at [s*RULE_W +: RULE_W]
- rsp_valid  out  1  readback response valid
- rsp_ready  in  1  response accept
- rsp_status  out  2  0 ok, 1 timeout, 2 bad stage
- rsp_data  out  RULE_W  read data
- err_drop_cnt  out  16  saturating framing-error count

Behaviour:
- Reset: all outputs 0, type_info 0, state IDLE.
- A beat is consumed only when pktin_data_wr && pktin_ready. Idle cycles mid-packet are ignored without error.
- pktin_ready is combinational from state: 1 in IDLE, META, CFG_HI, CFG_LO, DROP; 0 otherwise.
- Header beat fields:
  - [0] kind: 0 metadata, 1 config
  - [8] read
  - [16+:ADDR_W] addr
  - [31:24] stage: 0 = type info, 1..NUM_STAGES = rule stage
- IDLE: a head beat (flag 01) goes to META (kind 0) or CFG_HI (kind 1). Any other flag: err++, go to DROP.
- META: beat k (k = 0..META_BEATS-1) writes metadata[PHV_W-1-k*BEAT_W -: BEAT_W] (MSB first).
  - Beat META_BEATS-1 must carry tail: then latch type_info into the top field, phv_out_valid=1 next cycle, go to PHV_HOLD.
  - Tail earlier than that: err++, discard, go to IDLE.
  - Non-tail at the last index: err++, go to DROP.
- PHV_HOLD: phv_out and phv_out_valid are held stable until phv_out_ready. On ready, valid drops next cycle and the state returns to IDLE. Throughput is one PHV per META_BEATS+2 cycles minimum.
- CFG_HI: data_rule[RULE_W-1:BEAT_W] <= payload[RULE_W-BEAT_W-1:0].
- CFG_LO: data_rule[BEAT_W-1:0] <= payload; the beat must be tail, else err++ and go to DROP.
- Write dispatch:
  - Stage 0 write: type_info <= data_rule[TYPE_W-1:0].
  - Stage 1..N write: wren_rule[s-1] is a single-cycle pulse with addr/data stable that cycle and held until the next config.
  - Stage > N write: ignored, err++.
- Read dispatch:
  - Stage 0 read: rsp_data = zero-extended type_info, status 0.
  - Stage 1..N read: rden_rule[s-1] pulses one cycle, then RD_WAIT counts. The first rdata_rule_valid[s-1] captures data with status 0. At RD_TIMEOUT cycles: status 1, data 0.
  - Stage > N read: status 2, data 0.
  - All reads end in RSP.
- RSP: rsp_valid is held until rsp_ready, then returns to IDLE.
- DROP: consume beats until a tail, then go to IDLE.
- Simultaneous events: type-info write and PHV latch never coincide (single FSM); a PHV latched after a stage-0 write uses the new value.
- err_drop_cnt saturates at 0xFFFF.
- rst_n assertion mid-packet aborts everything: the partial PHV is discarded and no strobes are emitted.

Decomposition:
- Shared package: beat flag constants (HEAD/MID/TAIL), header field offsets, rsp status codes, FSM state encoding.
- One sub-module, phv_beat_deser: META counter plus PHV shift/insert register with framing check, parametrised by BEAT_W/PHV_W.

Test Plan:
- Write stage 0 with type info 0xA5 (low bits), then an 8-beat metadata packet with payloads 0..7 and phv_out_ready=1 -> phv_out[1023:896]=0, [127:0]=7, type field=0xA5, valid 1 cycle.
- Same PHV with phv_out_ready held 0 for 20 cycles -> phv_out stable, pktin_ready=0, a next-packet head is not consumed until ready.
- Config write stage 2, addr 5, data {0x1_2345_6789_ABCD, 128'h1} -> wren_rule=3'b010 for exactly one cycle, addr_rule=5, data_rule matches.
- Config read stage 3 with model returning valid after 4 cycles, value 0x1F -> rsp_valid, status 0, rsp_data=0x1F; read stage 1 never answered -> status 1 after 64 cycles; read stage 7 -> status 2.
- Metadata tail on beat 4 -> no phv_out_valid, err_drop_cnt=1; a following good packet is delivered.
- rst_n low after beat 3 of metadata -> all outputs 0; the next full packet is delivered correctly.
